// File: rtl/cpu_pkg.sv
// Shared types and defaults for the fetch front end.
package cpu_pkg;

  localparam int CPU_WIDTH = 32;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_DROP
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// PC, instruction-memory and decoder handshakes of the fetch unit.
interface instr_fetch_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH
) ();

  logic [WIDTH-1:0] pc;
  logic             pc_valid;
  logic             pc_ready;
  logic             flush;
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] instr_pc;
  logic             instr_valid;
  logic             instr_ready;

  modport master (
    input  pc, pc_valid, flush, mem_ack, mem_rdata, instr_ready,
    output pc_ready, mem_req, mem_addr, instr, instr_pc, instr_valid
  );

  modport slave (
    output pc, pc_valid, flush, mem_ack, mem_rdata, instr_ready,
    input  pc_ready, mem_req, mem_addr, instr, instr_pc, instr_valid
  );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Small circular buffer of {address, instruction} pairs feeding the decoder.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int  DATA_W = 2 * CPU_WIDTH,
  parameter int  DEPTH  = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [DATA_W-1:0] head_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_push && !clear_i) mem_q[wptr_q] <= wdata_i;
  end

  // Storage is not reset, so an empty buffer presents zeros instead of stale words.
  assign head_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Fetch unit: one memory read per accepted PC, results queued in order for decode.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH,
  parameter int DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_t       state_q, state_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic               ready;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] head;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ready   = 1'b0;
    push    = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        ready = rst && !bus.flush && (count < CNT_W'(DEPTH));
        if (bus.pc_valid && ready) begin
          addr_d  = bus.pc;
          state_d = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (bus.mem_ack) begin
          push    = !bus.flush && !fifo_full;
          state_d = FETCH_IDLE;
        end else if (bus.flush) begin
          state_d = FETCH_DROP;
        end
      end
      // A killed read still has to finish on the memory side before the next one.
      FETCH_DROP: begin
        if (bus.mem_ack) state_d = FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.pc_ready    = ready;
  assign bus.mem_req     = (state_q != FETCH_IDLE);
  assign bus.mem_addr    = addr_q;
  assign bus.instr_valid = !fifo_empty;
  assign bus.instr_pc    = head[2*WIDTH-1:WIDTH];
  assign bus.instr       = head[WIDTH-1:0];
  assign pop             = !fifo_empty && bus.instr_ready;

  fetch_fifo #(
    .DATA_W (2 * WIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (bus.flush),
    .wdata_i ({addr_q, bus.mem_rdata}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count),
    .head_o  (head)
  );

endmodule
